instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter IMEM_WORDS, default 1024, instruction-memory depth in 32-bit words; power of two.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Stall  input  1  hazard stall from decode; hold PC and IF/ID.
REQ-006 Halt  input  1  stop fetching permanently until Reset.
REQ-007 RedirectValid  input  1  taken branch/jump this cycle.
REQ-008 RedirectTarget  input  32  byte address of redirect.
REQ-009 ImemAddress  output  32  byte address to instruction memory; memory uses bits [log2(IMEM_WORDS)+1:2].
REQ-010 ImemInstruction  input  32  word returned by instruction memory for ImemAddress, same cycle.
REQ-011 IF_ID_Instruction  output  32  registered fetched instruction.
REQ-012 IF_ID_PCPlus4  output  32  registered address of fetched instruction + 4.
REQ-013 IF_ID_Valid  output  1  IF/ID register holds a real instruction.
REQ-014 FetchCount  output  32  count of instructions delivered to IF/ID.
REQ-015 MisalignErr  output  1  sticky: a redirect target had nonzero bits [1:0].
REQ-016 RangeErr  output  1  sticky: PC addressed beyond IMEM_WORDS*4 bytes.

Function
REQ-017 ImemAddress shall equal the PC register combinationally; no other logic in this path.
REQ-018 FSM states: START, RUN, HALTED; START lasts exactly one cycle after Reset deassertion, then RUN.
REQ-019 In START: no capture, PC holds RESET_PC, IF_ID_Valid=0.
REQ-020 Priority per cycle in RUN: Halt > RedirectValid > Stall > normal fetch.
REQ-021 Normal fetch (RUN, no Halt/Redirect/Stall): IF_ID_Instruction<=ImemInstruction, IF_ID_PCPlus4<=PC+4, IF_ID_Valid<=1, PC<=PC+4, FetchCount+1.
REQ-022 Redirect (ignores Stall): PC<={RedirectTarget[31:2],2'b00}, IF_ID_Instruction<=0, IF_ID_Valid<=0, IF_ID_PCPlus4 holds, FetchCount holds.
REQ-023 Redirect with RedirectTarget[1:0]!=0 shall set MisalignErr; redirect still taken with low bits cleared.
REQ-024 Stall alone: PC, IF/ID registers and FetchCount hold unchanged.
REQ-025 PC+4 arithmetic is 32-bit modulo; 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-026 Fetch with PC >= IMEM_WORDS*4: set RangeErr, capture 32'h0 with IF_ID_Valid=0, PC still advances, FetchCount holds.
REQ-027 Halt in RUN: next state HALTED; PC holds; IF_ID_Valid<=0; Redirect/Stall that cycle ignored.
REQ-028 HALTED: all registers hold, IF_ID_Valid stays 0; only Reset exits.
REQ-029 Halt during START shall be ignored; START always proceeds to RUN.
REQ-030 FetchCount wraps modulo 2^32.

Reset
REQ-031 Reset asserted (any time, including mid-stall or mid-redirect) shall immediately force: state START, PC=RESET_PC, IF_ID_Instruction=0, IF_ID_PCPlus4=0, IF_ID_Valid=0, FetchCount=0, MisalignErr=0, RangeErr=0.
REQ-032 No output shall change on Clk while Reset is high.

Structure
REQ-033 FSM state encoding, NOP word (32'h0) and PC increment (4) shall live in a shared processor package.
REQ-034 One sub-module, program_counter (PC register with load/hold/increment), is natural; FSM, IF/ID register and counters stay in the top.
REQ-035 Instruction memory is external; this block shall not instantiate it.

Verification
REQ-036 Reset release, no stalls, memory word[i]=i*3 -> cycle 1 START Valid=0; then IF_ID_Instruction 0,3,6 with PCPlus4 4,8,12; FetchCount=3.
REQ-037 Stall high 3 cycles at PC=8 -> ImemAddress stays 8, IF/ID and FetchCount unchanged; resumes with word 6 at PCPlus4=12.
REQ-038 Stall and RedirectValid with target 0x40 same cycle -> next ImemAddress=0x40, Valid=0; following cycle Instruction=48, PCPlus4=0x44.
REQ-039 Redirect to 0x43 -> ImemAddress=0x40, MisalignErr=1, held until Reset; redirect to 0x1000 -> RangeErr=1, Valid=0, PC advances to 0x1004.
REQ-040 Halt with RedirectValid at PC=0x10 -> HALTED, PC stays 0x10, Valid=0 for 10 cycles; async Reset mid-cycle -> all outputs zero immediately, START then RUN from RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared processor definitions for the fetch stage: FSM state encoding,
// the NOP word loaded into IF/ID on bubbles, and the sequential PC step.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INCR  = 32'd4;

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter register with load / increment / hold.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset (to RESET_PC)
//   i_load        load i_target (takes priority over i_incr)
//   i_target      word-aligned load value
//   i_incr        advance by PC_INCR, modulo 2^32
//   o_pc          current PC
module program_counter
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_target,
  input  logic        i_incr,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_target;
    end else if (i_incr) begin
      r_pc <= r_pc + PC_INCR;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: drives the external instruction memory address
// from the PC and captures the returned word into the IF/ID register.
// Ports:
//   Clk, Reset           clock, asynchronous active-high reset
//   Stall                hold PC and IF/ID
//   Halt                 stop fetching until Reset
//   RedirectValid/Target taken branch/jump (target low bits cleared)
//   ImemAddress          byte address to memory (= PC)
//   ImemInstruction      memory word for ImemAddress, same cycle
//   IF_ID_*              registered instruction, PC+4, valid flag
//   FetchCount           instructions delivered to IF/ID
//   MisalignErr          sticky: redirect target not word aligned
//   RangeErr             sticky: fetch beyond IMEM_WORDS*4 bytes
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Halt,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] ImemAddress,
  input  logic [31:0] ImemInstruction,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic [31:0] FetchCount,
  output logic        MisalignErr,
  output logic        RangeErr
);

  localparam int unsigned ADDR_BITS = $clog2(IMEM_WORDS) + 2;

  fetch_state_t r_state;
  logic [31:0]  r_instr;
  logic [31:0]  r_pc_plus4;
  logic         r_valid;
  logic [31:0]  r_count;
  logic         r_misalign;
  logic         r_range;

  logic [31:0]  w_pc;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_target;
  logic         w_run;
  logic         w_pc_load;
  logic         w_pc_incr;
  logic         w_in_range;

  assign w_run      = (r_state == ST_RUN);
  assign w_pc_load  = w_run && !Halt && RedirectValid;
  assign w_pc_incr  = w_run && !Halt && !RedirectValid && !Stall;
  assign w_target   = {RedirectTarget[31:2], 2'b00};
  assign w_pc_plus4 = w_pc + PC_INCR;
  // PC is in range when no bits at or above the memory byte-address width are set.
  assign w_in_range = (ADDR_BITS >= 32) ? 1'b1 : ((w_pc >> ADDR_BITS) == '0);

  program_counter #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .i_clk    (Clk),
    .i_rst    (Reset),
    .i_load   (w_pc_load),
    .i_target (w_target),
    .i_incr   (w_pc_incr),
    .o_pc     (w_pc)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_START;
      r_instr    <= NOP_WORD;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
      r_count    <= '0;
      r_misalign <= 1'b0;
      r_range    <= 1'b0;
    end else begin
      case (r_state)
        ST_START: begin
          r_state <= ST_RUN;
          r_valid <= 1'b0;
        end
        ST_RUN: begin
          if (Halt) begin
            r_state <= ST_HALTED;
            r_valid <= 1'b0;
          end else if (RedirectValid) begin
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
            if (RedirectTarget[1:0] != 2'b00) begin
              r_misalign <= 1'b1;
            end
          end else if (!Stall) begin
            if (w_in_range) begin
              r_instr    <= ImemInstruction;
              r_pc_plus4 <= w_pc_plus4;
              r_valid    <= 1'b1;
              r_count    <= r_count + 32'd1;
            end else begin
              // Out-of-range fetch becomes a bubble; PC+4 register left untouched.
              r_instr <= NOP_WORD;
              r_valid <= 1'b0;
              r_range <= 1'b1;
            end
          end
        end
        ST_HALTED: begin
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= ST_START;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ImemAddress       = w_pc;
  assign IF_ID_Instruction = r_instr;
  assign IF_ID_PCPlus4     = r_pc_plus4;
  assign IF_ID_Valid       = r_valid;
  assign FetchCount        = r_count;
  assign MisalignErr       = r_misalign;
  assign RangeErr          = r_range;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        Clk;
  logic        Reset;
  logic        Stall;
  logic        Halt;
  logic        RedirectValid;
  logic [31:0] RedirectTarget;
  logic [31:0] ImemAddress;
  logic [31:0] ImemInstruction;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic [31:0] FetchCount;
  logic        MisalignErr;
  logic        RangeErr;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] cnt;
    logic        valid;
    logic        mis;
    logic        rng;
    bit          chk_pc4;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_vec;
  int    n_err;

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (1024)
  ) dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .Stall             (Stall),
    .Halt              (Halt),
    .RedirectValid     (RedirectValid),
    .RedirectTarget    (RedirectTarget),
    .ImemAddress       (ImemAddress),
    .ImemInstruction   (ImemInstruction),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_PCPlus4     (IF_ID_PCPlus4),
    .IF_ID_Valid       (IF_ID_Valid),
    .FetchCount        (FetchCount),
    .MisalignErr       (MisalignErr),
    .RangeErr          (RangeErr)
  );

  // Memory model: word[i] = i*3, 1024 words.
  logic [9:0] mem_idx;
  assign mem_idx         = ImemAddress[11:2];
  assign ImemInstruction = 32'(mem_idx) * 32'd3;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                      input logic [31:0] pc4, input logic [31:0] cnt, input logic valid,
                      input logic mis, input logic rng, input bit chk_pc4);
    exp_t e;
    e.addr = addr; e.instr = instr; e.pc4 = pc4; e.cnt = cnt;
    e.valid = valid; e.mis = mis; e.rng = rng; e.chk_pc4 = chk_pc4;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    exp_t  e;
    string t;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    chk({t, ".addr"},  ImemAddress,       e.addr);
    chk({t, ".instr"}, IF_ID_Instruction, e.instr);
    if (e.chk_pc4) chk({t, ".pc4"}, IF_ID_PCPlus4, e.pc4);
    chk({t, ".cnt"},   FetchCount,        e.cnt);
    chk({t, ".valid"}, 32'(IF_ID_Valid),  32'(e.valid));
    chk({t, ".mis"},   32'(MisalignErr),  32'(e.mis));
    chk({t, ".rng"},   32'(RangeErr),     32'(e.rng));
  endtask

  task automatic drive(input logic st, input logic ht, input logic rv, input logic [31:0] tgt);
    Stall = st; Halt = ht; RedirectValid = rv; RedirectTarget = tgt;
  endtask

  // Drive inputs, record the expected post-edge state, clock once, compare.
  task automatic step(input string tag, input logic st, input logic ht, input logic rv,
                      input logic [31:0] tgt, input logic [31:0] addr, input logic [31:0] instr,
                      input logic [31:0] pc4, input logic [31:0] cnt, input logic valid,
                      input logic mis, input logic rng, input bit chk_pc4);
    drive(st, ht, rv, tgt);
    push(tag, addr, instr, pc4, cnt, valid, mis, rng, chk_pc4);
    @(posedge Clk);
    #1;
    pop_check();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    Reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    push("reset", 32'h0, 32'h0, 32'h0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    pop_check();
    @(negedge Clk);
    Reset = 1'b0;

    //          tag         St   Ht   RV   tgt           addr         instr   pc4          cnt  V    Mis  Rng  pc4?
    step("start",        0, 0, 0, 32'h0,       32'h0,       32'd0,  32'h0,       0, 0, 0, 0, 1);
    step("fetch0",       0, 0, 0, 32'h0,       32'h4,       32'd0,  32'h4,       1, 1, 0, 0, 1);
    step("fetch1",       0, 0, 0, 32'h0,       32'h8,       32'd3,  32'h8,       2, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      step("stall",      1, 0, 0, 32'h0,       32'h8,       32'd3,  32'h8,       2, 1, 0, 0, 1);
    step("fetch2",       0, 0, 0, 32'h0,       32'hC,       32'd6,  32'hC,       3, 1, 0, 0, 1);
    step("redir_stall",  1, 0, 1, 32'h40,      32'h40,      32'd0,  32'hC,       3, 0, 0, 0, 1);
    step("fetch_40",     0, 0, 0, 32'h0,       32'h44,      32'd48, 32'h44,      4, 1, 0, 0, 1);
    step("redir_43",     0, 0, 1, 32'h43,      32'h40,      32'd0,  32'h44,      4, 0, 1, 0, 1);
    step("refetch_40",   0, 0, 0, 32'h0,       32'h44,      32'd48, 32'h44,      5, 1, 1, 0, 1);
    step("redir_1000",   0, 0, 1, 32'h1000,    32'h1000,    32'd0,  32'h44,      5, 0, 1, 0, 1);
    step("range_fetch",  0, 0, 0, 32'h0,       32'h1004,    32'd0,  32'h0,       5, 0, 1, 1, 0);
    step("redir_8",      0, 0, 1, 32'h8,       32'h8,       32'd0,  32'h0,       5, 0, 1, 1, 0);
    step("fetch_8",      0, 0, 0, 32'h0,       32'hC,       32'd6,  32'hC,       6, 1, 1, 1, 1);
    step("fetch_C",      0, 0, 0, 32'h0,       32'h10,      32'd9,  32'h10,      7, 1, 1, 1, 1);
    step("halt",         1, 1, 1, 32'h80,      32'h10,      32'd9,  32'h10,      7, 0, 1, 1, 1);
    for (int i = 0; i < 10; i++)
      step("halted",     i[0], 0, i[1], 32'h80, 32'h10,     32'd9,  32'h10,      7, 0, 1, 1, 1);

    // Asynchronous reset mid-cycle, held across an edge with activity on inputs.
    #2;
    Reset = 1'b1;
    #1;
    push("async_rst", 32'h0, 32'h0, 32'h0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    pop_check();
    step("rst_held",     1, 0, 1, 32'h40,      32'h0,       32'd0,  32'h0,       0, 0, 0, 0, 1);
    @(negedge Clk);
    Reset = 1'b0;
    step("start_halt",   0, 1, 0, 32'h0,       32'h0,       32'd0,  32'h0,       0, 0, 0, 0, 1);
    step("run_fetch0",   0, 0, 0, 32'h0,       32'h4,       32'd0,  32'h4,       1, 1, 0, 0, 1);
    step("redir_top",    0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd0, 32'h4,    1, 0, 0, 0, 1);
    step("pc_wrap",      0, 0, 0, 32'h0,       32'h0,       32'd0,  32'h0,       1, 0, 0, 1, 0);
    step("after_wrap",   0, 0, 0, 32'h0,       32'h4,       32'd0,  32'h4,       2, 1, 0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
